// File: rtl/multiport_regfile_if.sv
// Bus bundle for multiport_regfile: read ports, two write ports, issue/scoreboard signals.
// Parameters must match the attached multiport_regfile instance.
interface multiport_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = 5
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                we0;
  logic                we1;
  logic [AW-1:0]       wa0;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd0;
  logic [XLEN-1:0]     wd1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_rd,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_rd,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/multiport_regfile.sv
// Multi-read, dual-write register file with per-register busy scoreboard; r0 is hardwired zero.
// Optional same-cycle write-to-read bypass is enabled by defining MPRF_BYPASS_EN.
module multiport_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = 5
) (
  input logic               clk,
  input logic               reset,
  multiport_regfile_if.slave rf
);

  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [XLEN-1:0]  regs_d [1:NREGS-1];
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_d;

  logic             wr0_ok;
  logic             wr1_ok;
  logic             iss_ok;
  logic [NREGS-1:0] busy_vec_c;

  assign wr0_ok = rf.we0 && (rf.wa0 != '0);
  assign wr1_ok = rf.we1 && (rf.wa1 != '0);
  assign iss_ok = rf.iss_valid && (rf.iss_rd != '0);

  // Port 1 is applied after port 0 so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wr0_ok && (rf.wa0 == AW'(i))) regs_d[i] = rf.wd0;
      if (wr1_ok && (rf.wa1 == AW'(i))) regs_d[i] = rf.wd1;
    end
  end

  // Issue set is applied last: a newer pending write outranks a completing one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wr0_ok && (rf.wa0 == AW'(i))) busy_d[i] = 1'b0;
      if (wr1_ok && (rf.wa1 == AW'(i))) busy_d[i] = 1'b0;
      if (iss_ok && (rf.iss_rd == AW'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec_c  = {busy_q, 1'b0};
  assign rf.busy_vec = busy_vec_c;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rf.rd_addr[k*AW +: AW];

    always_comb begin
      data = '0;
      for (int i = 1; i < NREGS; i++) begin
        if (addr == AW'(i)) data = regs_q[i];
      end
      busy = busy_vec_c[addr];
`ifdef MPRF_BYPASS_EN
      if (wr0_ok && (rf.wa0 == addr)) begin
        data = rf.wd0;
        busy = iss_ok && (rf.iss_rd == addr);
      end
      if (wr1_ok && (rf.wa1 == addr)) begin
        data = rf.wd1;
        busy = iss_ok && (rf.iss_rd == addr);
      end
`endif
      // Outputs forced low during reset so a bypassed write cannot leak through.
      if (reset) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rf.rd_data[k*XLEN +: XLEN] = data;
    assign rf.rd_busy[k]              = busy;
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench for multiport_regfile: directed vector table, hand sequences, random vs model.
module tb_multiport_regfile;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  multiport_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .AW(AW)) bus ();

  multiport_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge given the inputs currently driven.
  task automatic model_edge();
    if (bus.we0 && bus.wa0 != 0) begin m_regs[bus.wa0] = bus.wd0; m_busy[bus.wa0] = 1'b0; end
    if (bus.we1 && bus.wa1 != 0) begin m_regs[bus.wa1] = bus.wd1; m_busy[bus.wa1] = 1'b0; end
    if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = (a == 0) ? '0 : m_regs[a];
`ifdef MPRF_BYPASS_EN
    if (a != 0 && bus.we0 && bus.wa0 == a) v = bus.wd0;
    if (a != 0 && bus.we1 && bus.wa1 == a) v = bus.wd1;
`endif
    return v;
  endfunction

  function automatic logic exp_rbusy(input logic [AW-1:0] a);
    logic b;
    b = m_busy[a];
`ifdef MPRF_BYPASS_EN
    if (a != 0 && ((bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a)))
      b = bus.iss_valid && (bus.iss_rd == a);
`endif
    return b;
  endfunction

  function automatic logic [NREGS-1:0] exp_bvec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ports(input string tag);
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      a = bus.rd_addr[k*AW +: AW];
      check($sformatf("%s rd_data[%0d] a=%0d", tag, k, a), 64'(bus.rd_data[k*XLEN +: XLEN]), 64'(exp_data(a)));
      check($sformatf("%s rd_busy[%0d] a=%0d", tag, k, a), 64'(bus.rd_busy[k]), 64'(exp_rbusy(a)));
    end
    check({tag, " busy_vec"}, 64'(bus.busy_vec), 64'(exp_bvec()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic            iss;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   chk_addr;
    logic [XLEN-1:0] exp_rd;
    logic [NREGS-1:0] exp_busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive_idle();
    set_rd('0, '0);
    model_reset();

    // Reset state on every address and port.
    #2;
    for (int a = 0; a < NREGS; a++) begin
      set_rd(AW'(a), AW'(NREGS - 1 - a));
      #1;
      check_ports("reset");
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors: one edge of stimulus, then idle read-back.
    vecs[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  5'd3,  32'h12345678, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  32'h0,        32'h0000_0080};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h00000077, 1'b1, 5'd7,  5'd7,  32'h00000077, 32'h0000_0080};
    vecs[4] = '{1'b1, 5'd7,  32'h00000070, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  32'h00000070, 32'h0};
    vecs[5] = '{1'b1, 5'd31, 32'h0000CAFE, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd31, 32'h0000CAFE, 32'h8000_0000};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'h0000BEEF, 1'b0, 5'd0,  5'd31, 32'h0000BEEF, 32'h0};
    vecs[7] = '{1'b1, 5'd1,  32'h00001111, 1'b1, 5'd2,  32'h00002222, 1'b0, 5'd0,  5'd1,  32'h00001111, 32'h0};

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      bus.we0 = vecs[v].we0; bus.wa0 = vecs[v].wa0; bus.wd0 = vecs[v].wd0;
      bus.we1 = vecs[v].we1; bus.wa1 = vecs[v].wa1; bus.wd1 = vecs[v].wd1;
      bus.iss_valid = vecs[v].iss; bus.iss_rd = vecs[v].iss_rd;
      clock_edge();
      drive_idle();
      set_rd(vecs[v].chk_addr, vecs[v].chk_addr);
      #1;
      check($sformatf("vec%0d rd_data0", v), 64'(bus.rd_data[XLEN-1:0]), 64'(vecs[v].exp_rd));
      check($sformatf("vec%0d rd_data1", v), 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'(vecs[v].exp_rd));
      check($sformatf("vec%0d busy_vec", v), 64'(bus.busy_vec), 64'(vecs[v].exp_busy));
      check($sformatf("vec%0d rd_busy0", v), 64'(bus.rd_busy[0]), 64'(vecs[v].exp_busy[vecs[v].chk_addr]));
    end

    // Same-cycle read of a register being written (bypass vs. registered visibility).
    @(negedge clk);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    clock_edge();
    drive_idle();
    @(negedge clk);
    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hA5A5A5A5;
    set_rd(5'd5, 5'd5);
    #1;
`ifdef MPRF_BYPASS_EN
    check("bypass same-cycle data", 64'(bus.rd_data[XLEN-1:0]), 64'h0A5A5A5A5);
    check("bypass same-cycle busy", 64'(bus.rd_busy[0]), 64'h0);
`else
    check("nobypass same-cycle data", 64'(bus.rd_data[XLEN-1:0]), 64'h0);
    check("nobypass same-cycle busy", 64'(bus.rd_busy[0]), 64'h1);
`endif
    check_ports("r5 write cycle");
    clock_edge();
    drive_idle();
    #1;
    check("r5 next-cycle data", 64'(bus.rd_data[XLEN-1:0]), 64'h0A5A5A5A5);
    check("r5 next-cycle busy", 64'(bus.busy_vec[5]), 64'h0);

    // Write plus re-issue of the same register in one cycle.
    @(negedge clk);
    bus.we1 = 1'b1; bus.wa1 = 5'd5; bus.wd1 = 32'h5A5A5A5A;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    #1;
`ifdef MPRF_BYPASS_EN
    check("bypass+issue data", 64'(bus.rd_data[XLEN-1:0]), 64'h05A5A5A5A);
    check("bypass+issue busy", 64'(bus.rd_busy[0]), 64'h1);
`else
    check("nobypass+issue data", 64'(bus.rd_data[XLEN-1:0]), 64'h0A5A5A5A5);
    check("nobypass+issue busy", 64'(bus.rd_busy[0]), 64'h0);
`endif
    clock_edge();
    drive_idle();
    #1;
    check("r5 reissued busy", 64'(bus.busy_vec[5]), 64'h1);
    check("r5 reissued data", 64'(bus.rd_data[XLEN-1:0]), 64'h05A5A5A5A);

    // Randomized traffic, addresses biased low to force collisions.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.we0 = 1'($urandom_range(0, 1));
      bus.wa0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 7));
      bus.wd0 = $urandom;
      bus.we1 = 1'($urandom_range(0, 1));
      bus.wa1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS - 1)) : AW'($urandom_range(0, 7));
      bus.wd1 = $urandom;
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd = AW'($urandom_range(0, 7));
      set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, NREGS - 1)));
      #1;
      check_ports($sformatf("rand%0d", c));
      clock_edge();
    end

    // Load known state, then assert reset between edges.
    @(negedge clk);
    drive_idle();
    bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h00000099;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd10;
    clock_edge();
    drive_idle();
    set_rd(5'd9, 5'd10);
    #1;
    check("pre-reset r9", 64'(bus.rd_data[XLEN-1:0]), 64'h99);
    check("pre-reset busy10", 64'(bus.busy_vec[10]), 64'h1);
    @(negedge clk);
    #2;
    bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'h00001234;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    reset = 1'b1;
    model_reset();
    #1;
    check("async reset rd_data", 64'(bus.rd_data), 64'h0);
    check("async reset busy_vec", 64'(bus.busy_vec), 64'h0);
    check("async reset rd_busy", 64'(bus.rd_busy), 64'h0);
    @(posedge clk);
    #1;
    check("held reset rd_data", 64'(bus.rd_data), 64'h0);
    check("held reset busy_vec", 64'(bus.busy_vec), 64'h0);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    check_ports("post-reset");

    // Normal operation resumes after reset.
    @(negedge clk);
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h00000055;
    clock_edge();
    drive_idle();
    #1;
    check("resume r9", 64'(bus.rd_data[XLEN-1:0]), 64'h55);
    check_ports("resume");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; a power of two, minimum 4.
REQ-003 Parameter NRD, default 2, number of read ports; range 1 to 4.
REQ-004 Parameter AW, default 5, register address width; equals log2(NREGS).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 rd_addr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-008 rd_data  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-009 rd_busy  output  NRD  port k is high when its addressed register has a pending write.
REQ-010 we0, we1  input  1 each  write enables for write ports 0 and 1.
REQ-011 wa0, wa1  input  AW each  write addresses.
REQ-012 wd0, wd1  input  XLEN each  write data.
REQ-013 iss_valid  input  1  an instruction issues this cycle and will later write register iss_rd.
REQ-014 iss_rd  input  AW  destination register of the issuing instruction.
REQ-015 busy_vec  output  NREGS  current scoreboard bits, one per register.

Function
REQ-016 Register 0 shall read as zero at all times; writes to it shall be discarded, and it shall never become busy.
REQ-017 Reads shall be combinational: rd_data port k shall equal the register selected by rd_addr port k.
REQ-018 On a rising clk edge, a write port with its enable high and a nonzero address shall store its data.
REQ-019 When both write ports are enabled with the same nonzero address, write port 1 shall win.
REQ-020 On a rising clk edge, iss_valid high with nonzero iss_rd shall set busy_vec[iss_rd].
REQ-021 An enabled write port with a nonzero address shall clear busy_vec at that address on the same edge.
REQ-022 If issue and a write target the same register in one cycle, set shall win, so the bit ends high because a newer write is pending.
REQ-023 rd_busy port k shall equal busy_vec[rd_addr port k], subject to REQ-027.
REQ-024 A write to a register that is not busy shall still update the register; the scoreboard shall not gate writes.
REQ-025 State depth shall be NREGS-1 storage words plus NREGS-1 busy flops; no register 0 storage shall be inferred.

Reset
REQ-026 While reset is high, all registers and all busy bits shall be zero asynchronously, all rd_data shall be zero, and writes and issues shall be ignored; normal operation shall resume on the first rising clk edge after reset deasserts.

Configuration
REQ-027 With macro MPRF_BYPASS_EN defined:
- rd_data port k shall return the same-cycle write data when an enabled write port targets its nonzero rd_addr, with port 1 taking priority.
- rd_busy port k shall be low in that cycle, unless iss_valid with the same iss_rd is also high.
REQ-028 Without MPRF_BYPASS_EN:
- rd_data shall return the stored value, so written data becomes visible one cycle after the write edge.
- rd_busy shall reflect busy_vec only.

Verification
REQ-029 Reset, then read all addresses on every port -> all rd_data are 0 and busy_vec is 0.
REQ-030 we0=1, wa0=3, wd0=0xDEADBEEF, and in the same cycle we1=1, wa1=3, wd1=0x12345678; then read address 3 -> 0x12345678.
REQ-031 we0=1, wa0=0, wd0=0xFFFFFFFF, and iss_valid=1, iss_rd=0 -> address 0 reads 0 and busy_vec[0]=0.
REQ-032 iss_valid=1, iss_rd=7, then we1=1, wa1=7 together with iss_valid=1, iss_rd=7 -> busy_vec[7] stays 1; a further write to 7 alone -> busy_vec[7]=0.
REQ-033 Read address 5 while we0=1, wa0=5, wd0=0xA5A5A5A5 -> with MPRF_BYPASS_EN, 0xA5A5A5A5 and rd_busy=0 in the same cycle; without it, the old value that cycle and 0xA5A5A5A5 next cycle.
REQ-034 Assert reset mid-stream with busy_vec nonzero and registers loaded -> all outputs are 0 immediately, before any clk edge.
